// File: rtl/axi_to_apb_bridge.sv
// rtl/axi_to_apb_bridge.sv - single-beat AXI4 slave to APB master bridge; optional macro APB_TIMEOUT_EN bounds the ACCESS wait
module axi_to_apb_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_n_i,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]                  aw_len_i,
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                        w_last_i,
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    output logic [AXI_ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]                  b_resp_o,
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]                  ar_len_i,
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    output logic [AXI_ID_WIDTH-1:0]     r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [AXI_DATA_WIDTH-1:0]   pwdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] pstrb_o,
    output logic [2:0]                  pprot_o,
    input  logic                        pready_i,
    input  logic [AXI_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pslverr_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_WDRAIN = 3'd3;
    localparam logic [2:0] S_WRESP  = 3'd4;
    localparam logic [2:0] S_RRESP  = 3'd5;

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Reject parameter sets the datapath cannot represent.
    if (AXI_DATA_WIDTH != APB_DATA_WIDTH || APB_ADDR_WIDTH > AXI_ADDR_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi_to_apb_bridge: invalid parameter set");
    end

    logic [2:0]                state;
    logic                      last_write;   // 1 when the most recent completed grant was a write
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     strb_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      wr_q;
    logic [1:0]                resp_q;
    logic [7:0]                beats_q;      // read beats still owed after the current one

    logic idle;
    logic wr_elig;
    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic apb_active;
    logic tmo_hit;

    assign idle     = (state == S_IDLE);
    assign wr_elig  = aw_valid_i & w_valid_i;
    assign rd_elig  = ar_valid_i;
    // On a tie the side that did not go last wins.
    assign grant_wr = idle & wr_elig & (~rd_elig | ~last_write);
    assign grant_rd = idle & rd_elig & ~grant_wr;

    assign aw_ready_o = grant_wr;
    assign w_ready_o  = grant_wr | (state == S_WDRAIN);
    assign ar_ready_o = grant_rd;

    assign apb_active = (state == S_SETUP) | (state == S_ACCESS);
    assign psel_o     = apb_active;
    assign penable_o  = (state == S_ACCESS);
    assign pwrite_o   = apb_active & wr_q;
    assign paddr_o    = addr_q;
    assign pwdata_o   = wdata_q;
    assign pstrb_o    = strb_q;
    assign pprot_o    = 3'b000;

    assign b_valid_o = (state == S_WRESP);
    assign b_id_o    = id_q;
    assign b_resp_o  = resp_q;
    assign r_valid_o = (state == S_RRESP);
    assign r_id_o    = id_q;
    assign r_data_o  = rdata_q;
    assign r_resp_o  = resp_q;
    assign r_last_o  = (state == S_RRESP) & (beats_q == 8'd0);

`ifdef APB_TIMEOUT_EN
    localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_WIDTH-1:0] tmo_cnt;

    // The last stalled ACCESS cycle before the limit is the one that gives up.
    assign tmo_hit = (state == S_ACCESS) & ~pready_i & (tmo_cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles; SETUP always precedes ACCESS, so clearing there restarts each transfer.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt <= '0;
        end else if (state == S_SETUP) begin
            tmo_cnt <= '0;
        end else if (state == S_ACCESS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Main transaction sequencer: arbitration, capture, APB phases and AXI responses.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            last_write <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            wr_q       <= 1'b0;
            resp_q     <= RESP_OKAY;
            beats_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        id_q   <= aw_id_i;
                        addr_q <= aw_addr_i[APB_ADDR_WIDTH-1:0];
                        wr_q   <= 1'b1;
                        if (aw_len_i == 8'd0) begin
                            wdata_q <= w_data_i;
                            strb_q  <= w_strb_i;
                            state   <= S_SETUP;
                        end else begin
                            wdata_q <= '0;
                            strb_q  <= '0;
                            resp_q  <= RESP_SLVERR;
                            state   <= w_last_i ? S_WRESP : S_WDRAIN;
                        end
                    end else if (grant_rd) begin
                        id_q    <= ar_id_i;
                        addr_q  <= ar_addr_i[APB_ADDR_WIDTH-1:0];
                        wr_q    <= 1'b0;
                        wdata_q <= '0;
                        strb_q  <= '0;
                        if (ar_len_i == 8'd0) begin
                            state <= S_SETUP;
                        end else begin
                            rdata_q <= '0;
                            resp_q  <= RESP_SLVERR;
                            beats_q <= ar_len_i;
                            state   <= S_RRESP;
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        resp_q  <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
                        rdata_q <= wr_q ? '0 : prdata_i;
                        beats_q <= '0;
                        state   <= wr_q ? S_WRESP : S_RRESP;
                    end else if (tmo_hit) begin
                        resp_q  <= RESP_SLVERR;
                        rdata_q <= '0;
                        beats_q <= '0;
                        state   <= wr_q ? S_WRESP : S_RRESP;
                    end
                end
                S_WDRAIN: begin
                    if (w_valid_i && w_last_i) begin
                        state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (b_ready_i) begin
                        last_write <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (r_ready_i) begin
                        if (beats_q == 8'd0) begin
                            last_write <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            beats_q <= beats_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_to_apb_bridge.sv
// tb/tb_axi_to_apb_bridge.sv - self-checking bench for axi_to_apb_bridge
module tb_axi_to_apb_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr, w_data, r_data, paddr, pwdata, prdata;
    logic [7:0]  aw_len, ar_len;
    logic [3:0]  w_strb, pstrb;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
    logic [1:0]  b_resp, r_resp;
    logic        b_valid, b_ready, ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [2:0]  pprot;

    int n_cmp = 0;
    int n_fail = 0;
    bit last_write = 1'b0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    axi_to_apb_bridge dut (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pprot_o(pprot), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the address handshake (DUT in SETUP); returns at the negedge after the response handshake.
    task automatic serve(input bit wr, input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int waits, input bit err, input int hold);
        logic [31:0] rd;
        logic [31:0] merged;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwdata", pwdata, wr ? data : 32'h0);
        chk("setup_pstrb", pstrb, wr ? strb : 4'h0);
        chk("setup_pprot", pprot, 0);
        rd = mem.exists(addr) ? mem[addr] : $urandom;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            chk("access_sel_en", {psel, penable}, 2'b11);
            chk("access_paddr", paddr, addr);
            chk("access_pwrite", pwrite, wr);
            pready  = (k == waits);
            pslverr = err && (k == waits);
            prdata  = rd;
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        chk("resp_apb_idle", {psel, penable}, 2'b00);
        if (wr && !err) begin
            merged = mem.exists(addr) ? mem[addr] : 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) merged[b*8 +: 8] = data[b*8 +: 8];
            mem[addr] = merged;
        end
        for (int h = 0; h <= hold; h++) begin
            if (wr) begin
                chk("b_valid", b_valid, 1);
                chk("b_resp", b_resp, err ? 2'b10 : 2'b00);
                chk("b_id", b_id, id);
            end else begin
                chk("r_valid", r_valid, 1);
                chk("r_resp", r_resp, err ? 2'b10 : 2'b00);
                chk("r_data", r_data, rd);
                chk("r_last", r_last, 1);
                chk("r_id", r_id, id);
            end
            chk("no_accept_busy", {aw_ready, w_ready, ar_ready}, 3'b000);
            if (h == hold) begin
                if (wr) b_ready = 1'b1; else r_ready = 1'b1;
            end
            @(negedge clk);
        end
        b_ready = 1'b0; r_ready = 1'b0;
        chk("resp_done", {b_valid, r_valid}, 2'b00);
        last_write = wr;
    endtask

    task automatic put_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        aw_id = id; aw_addr = addr; aw_len = 8'd0; w_data = data; w_strb = strb; w_last = 1'b1;
        aw_valid = 1'b1; w_valid = 1'b1;
    endtask

    task automatic put_read(input logic [3:0] id, input logic [31:0] addr);
        ar_id = id; ar_addr = addr; ar_len = 8'd0; ar_valid = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int waits, input bit err, input int hold);
        put_write(id, addr, data, strb);
        #1;
        chk("aw_w_ready", {aw_ready, w_ready}, 2'b11);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        serve(1'b1, id, addr, data, strb, waits, err, hold);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int waits, input bit err, input int hold);
        put_read(id, addr);
        #1;
        chk("ar_ready", ar_ready, 1);
        @(negedge clk);
        ar_valid = 1'b0;
        serve(1'b0, id, addr, 32'h0, 4'h0, waits, err, hold);
    endtask

    // Both sides request together; round-robin decides the order.
    task automatic do_both(input logic [3:0] wid, input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [3:0] rid, input logic [31:0] raddr, input int waits, input bit err);
        bit write_first;
        write_first = !last_write;
        put_write(wid, waddr, wdata, wstrb);
        put_read(rid, raddr);
        #1;
        chk("tie_aw_ready", aw_ready, write_first);
        chk("tie_ar_ready", ar_ready, !write_first);
        @(negedge clk);
        if (write_first) begin
            aw_valid = 1'b0; w_valid = 1'b0;
            serve(1'b1, wid, waddr, wdata, wstrb, waits, err, 2);
            #1;
            chk("second_ar_ready", ar_ready, 1);
            @(negedge clk);
            ar_valid = 1'b0;
            serve(1'b0, rid, raddr, 32'h0, 4'h0, waits, err, 0);
        end else begin
            ar_valid = 1'b0;
            serve(1'b0, rid, raddr, 32'h0, 4'h0, waits, err, 2);
            #1;
            chk("second_aw_ready", {aw_ready, w_ready}, 2'b11);
            @(negedge clk);
            aw_valid = 1'b0; w_valid = 1'b0;
            serve(1'b1, wid, waddr, wdata, wstrb, waits, err, 0);
        end
    endtask

    initial begin
        aw_id = 0; aw_addr = 0; aw_len = 0; aw_valid = 0;
        w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0;
        ar_id = 0; ar_addr = 0; ar_len = 0; ar_valid = 0; r_ready = 0;
        pready = 0; prdata = 0; pslverr = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_apb", {psel, penable, pwrite}, 3'b000);
        chk("rst_valids", {b_valid, r_valid, r_last}, 3'b000);
        chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata_pstrb", {pwdata, pstrb}, 0);
        chk("rst_resp", {b_id, b_resp, r_id, r_resp, r_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed plan items.
        do_write(4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
        mem[32'h0000_0020] = 32'h1234_5678;
        do_read(4'h5, 32'h0000_0020, 3, 1'b0, 0);
        do_write(4'h6, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 1, 1'b1, 0);
        do_read(4'h2, 32'h0000_0010, 0, 1'b1, 0);
        do_both(4'hA, 32'h0000_0040, 32'h1111_2222, 4'hF, 4'hB, 32'h0000_0040, 0, 1'b0);
        do_write(4'h1, 32'h0000_0044, 32'h5555_AAAA, 4'hC, 0, 1'b0, 0);
        do_both(4'hC, 32'h0000_0044, 32'h7777_8888, 4'hF, 4'hD, 32'h0000_0044, 2, 1'b0);
        do_write(4'h4, 32'h0000_0048, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 5);
        do_read(4'h9, 32'h0000_0048, 0, 1'b0, 5);

        // Write burst: aw_len=3, four W beats, no APB traffic, one SLVERR.
        aw_id = 4'h7; aw_addr = 32'h50; aw_len = 8'd3; aw_valid = 1'b1;
        w_data = $urandom; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
        #1;
        chk("bw_ready", {aw_ready, w_ready}, 2'b11);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int b = 2; b <= 4; b++) begin
            w_last = (b == 4);
            w_data = $urandom;
            #1;
            chk("bw_drain", {aw_ready, w_ready, psel, b_valid}, 4'b0100);
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk("bw_b_valid", b_valid, 1);
        chk("bw_b_resp", b_resp, 2'b10);
        chk("bw_b_id", b_id, 4'h7);
        chk("bw_no_psel", psel, 0);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("bw_done", b_valid, 0);
        last_write = 1'b1;

        // Read burst: ar_len=1, two SLVERR beats, r_last on the second.
        ar_id = 4'h9; ar_addr = 32'h60; ar_len = 8'd1; ar_valid = 1'b1;
        #1;
        chk("br_ready", ar_ready, 1);
        @(negedge clk);
        ar_valid = 1'b0;
        chk("br_beat1", {r_valid, r_last, r_resp, psel}, 5'b10100);
        chk("br_beat1_data", {r_id, r_data}, {4'h9, 32'h0});
        r_ready = 1'b1;
        @(negedge clk);
        chk("br_beat2", {r_valid, r_last, r_resp, psel}, 5'b11100);
        chk("br_beat2_data", {r_id, r_data}, {4'h9, 32'h0});
        @(negedge clk);
        r_ready = 1'b0;
        chk("br_done", r_valid, 0);
        last_write = 1'b0;

        // Randomized traffic against the memory model and round-robin model.
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a1, a2, d;
            int sel;
            a1 = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
            a2 = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
            d = $urandom;
            sel = $urandom_range(0, 2);
            if (sel == 0)
                do_write(4'($urandom), a1, d, 4'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            else if (sel == 1)
                do_read(4'($urandom), a1, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            else
                do_both(4'($urandom), a1, d, 4'($urandom), 4'($urandom), a2, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

`ifdef APB_TIMEOUT_EN
        // Stuck slave: give up after 255 ACCESS cycles with SLVERR and zero data.
        put_read(4'hE, 32'h70);
        #1;
        chk("tmo_ar_ready", ar_ready, 1);
        @(negedge clk);
        ar_valid = 1'b0;
        pready = 1'b0;
        for (int c = 0; c < 255; c++) begin
            @(negedge clk);
            if (penable !== 1'b1) begin
                chk("tmo_access_held", penable, 1);
                break;
            end
        end
        @(negedge clk);
        chk("tmo_apb_idle", {psel, penable}, 2'b00);
        chk("tmo_r", {r_valid, r_resp, r_last, r_id}, {1'b1, 2'b10, 1'b1, 4'hE});
        chk("tmo_r_data", r_data, 0);
        pready = 1'b1; prdata = 32'hFFFF_FFFF;
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; pready = 1'b0; prdata = 32'h0;
        chk("tmo_done", {r_valid, psel}, 2'b00);
        last_write = 1'b0;
`endif

        // Reset mid-transfer: APB drops at once and no response follows.
        put_write(4'hF, 32'h0000_0080, 32'h1234_ABCD, 4'hF);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        chk("mid_access", {psel, penable}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_apb", {psel, penable, pwrite}, 3'b000);
        chk("mid_rst_paddr", paddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_no_resp", {b_valid, r_valid, psel}, 3'b000);
        last_write = 1'b0;
        do_both(4'h2, 32'h0000_0004, 32'h0F0F_0F0F, 4'hF, 4'h3, 32'h0000_0004, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
